pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the next-PC calculator.
- Holds the architectural PC and fetches the word at that PC from instruction memory over a valid/ready request channel with a single outstanding transaction.
- Presents `{if_pc, if_inst}` to decode under a valid/ready handshake.
- On each decode accept, loads the combinational `next_pc`; that value is derived from the instruction/PC currently on `if_inst` and `if_pc`.
- PC space is imem-relative: text base already subtracted, exception vector 0x00400004.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- XLEN, 32, PC and instruction width. Fixed at 32; no other value supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- next_pc  in  32  target PC from the next-PC calculator; sampled on decode accept or on flush.
- flush  in  1  exception/redirect. Abandons the in-flight fetch and loads `next_pc`.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_rsp_valid  in  1  one-cycle pulse; read data valid.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  `if_inst`/`if_pc` valid for decode.
- id_ready  in  1  decode accepts the instruction.
- if_inst  out  32  fetched instruction.
- if_pc  out  32  PC of `if_inst`.
- fetch_count  out  32  count of instructions accepted by decode.

Behaviour:
- Reset (`rst_n`=0 at edge) forces:
  - `pc`, `imem_addr`, `if_pc` = RESET_PC
  - `if_inst` = 0, `if_valid` = 0, `imem_req_valid` = 0
  - `fetch_count` = 0, `drop` = 0
  - state = BOOT
- Reset asserted in any state, including mid-transaction, aborts everything. A late `imem_rsp_valid` arriving after reset is ignored, because BOOT/REQ do not sample the response.
- FSM states: BOOT, REQ, WAIT, HOLD.
  - BOOT: lasts exactly one cycle, then REQ.
  - REQ: `imem_req_valid`=1, `imem_addr`=`pc`.
    - If `imem_req_ready`=1 → WAIT.
    - Otherwise stay; `imem_addr` is held stable.
  - WAIT: waits for `imem_rsp_valid`.
    - If `drop`=0: `if_inst` <= `imem_rsp_data`, `if_pc` <= `pc`, `if_valid` <= 1 → HOLD.
    - If `drop`=1: discard the response, clear `drop` → REQ.
  - HOLD: `if_valid`=1; `if_inst`/`if_pc` are held stable.
    - If `id_ready`=1: `if_valid` <= 0, `pc` <= `next_pc`, `fetch_count` += 1 (wraps at 2^32) → REQ.
- Minimum latency: REQ→WAIT 1 cycle; response one cycle later; `if_valid` the following cycle.
- Peak throughput: one instruction per 3 cycles with zero-wait memory.
- `flush` (highest priority after reset):
  - In any state: `pc` <= `next_pc`, `if_valid` <= 0, no `fetch_count` increment, state → REQ.
  - Exception: in WAIT with no `imem_rsp_valid` that cycle, set `drop`=1 and stay in WAIT, so one stale response is discarded before REQ.
  - In WAIT with `imem_rsp_valid`=1 the same cycle: the response is discarded, `drop` stays 0 → REQ.
  - In REQ with `imem_req_ready`=1 the same cycle: the request is committed, so → WAIT with `drop`=1.
- `flush` together with `id_ready` in HOLD: flush wins; no count increment.
- Sampling rules:
  - `next_pc` is sampled only on a HOLD accept or on flush.
  - `next_pc` and `if_pc` are used as-is; their low bits are not modified.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output `fetch_misalign` (1 bit, reset 0).
  - When `pc` is loaded with `next_pc[1:0]`≠0, the FSM enters HOLD directly with no memory request: `if_inst`=0, `if_pc`=`next_pc`, `if_valid`=1, `fetch_misalign`=1.
  - `fetch_misalign` clears on the next accept or flush.
- When undefined:
  - No extra port.
  - Misaligned PCs are fetched normally with `imem_addr`=`pc` unmodified.

Test Plan:
- Reset release, ready=1, rsp one cycle after grant with data 0x20080005, `id_ready`=1 → `imem_addr`=0; `if_valid` at cycle 4 after reset release with `if_inst`=0x20080005, `if_pc`=0; next `imem_addr`=`next_pc`=4; `fetch_count`=1.
- `imem_req_ready` low 3 cycles → `imem_req_valid` stays 1 and `imem_addr` stays stable; exactly one WAIT entry.
- `id_ready`=0 for 5 cycles in HOLD → `if_inst`/`if_pc` unchanged, no new request, `fetch_count` unchanged.
- `flush` with `next_pc`=0x00400004 in WAIT, stale rsp 2 cycles later → stale word never appears on `if_inst`; next `imem_addr`=0x00400004.
- `rst_n` low for one cycle while in WAIT, rsp arrives the next cycle → ignored; fetch restarts at RESET_PC, `fetch_count`=0.
- (FETCH_ALIGN_CHECK_EN) `next_pc`=0x00000006 → no `imem_req_valid`; `if_valid`=1, `fetch_misalign`=1, `if_pc`=6.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the PC, issues one imem read at a time and holds the word for decode (>=3 cycles/inst).
// Optional FETCH_ALIGN_CHECK_EN: a misaligned PC skips memory and is handed to decode with fetch_misalign set.
module pc_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] next_pc,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] inst_nxt, ipc_nxt, count_nxt;
  logic            valid_nxt;
  logic            drop, drop_nxt;
  logic            refetch;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misalign_nxt;
`endif

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = if_inst;
    ipc_nxt   = if_pc;
    valid_nxt = if_valid;
    count_nxt = fetch_count;
    drop_nxt  = drop;
    refetch   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_nxt = fetch_misalign;
`endif
    if (flush) begin
      pc_nxt    = next_pc;
      valid_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_nxt = 1'b0;
`endif
      // A read already granted but not yet answered must be swallowed later.
      if ((state == S_WAIT && !imem_rsp_valid) || (state == S_REQ && imem_req_ready)) begin
        drop_nxt  = 1'b1;
        state_nxt = S_WAIT;
      end else begin
        drop_nxt = 1'b0;
        refetch  = 1'b1;
      end
    end else begin
      case (state)
        S_BOOT: state_nxt = S_REQ;
        S_REQ: begin
          if (imem_req_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_nxt = 1'b0;
              refetch  = 1'b1;
            end else begin
              inst_nxt  = imem_rsp_data;
              ipc_nxt   = pc;
              valid_nxt = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            valid_nxt = 1'b0;
            pc_nxt    = next_pc;
            count_nxt = fetch_count + XLEN'(1);
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_nxt = 1'b0;
`endif
            refetch   = 1'b1;
          end
        end
        default: state_nxt = S_BOOT;
      endcase
    end

    if (refetch) begin
      state_nxt = S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc_nxt[1:0] != 2'b00) begin
        state_nxt    = S_HOLD;
        inst_nxt     = '0;
        ipc_nxt      = pc_nxt;
        valid_nxt    = 1'b1;
        misalign_nxt = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      if_pc       <= RESET_PC;
      if_inst     <= '0;
      if_valid    <= 1'b0;
      fetch_count <= '0;
      drop        <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_pc       <= ipc_nxt;
      if_inst     <= inst_nxt;
      if_valid    <= valid_nxt;
      fetch_count <= count_nxt;
      drop        <= drop_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= misalign_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: transaction-level PC/instruction model plus a latency-programmable memory.
module tb_pc_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = '0;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  pc_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .id_ready(id_ready), .if_inst(if_inst), .if_pc(if_pc),
    .fetch_count(fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  typedef struct { int due; logic [31:0] dat; } rsp_t;
  rsp_t mq[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_pc = RESET_PC, exp_cnt = '0, held_addr = '0, last_grant_addr = '0;
  int since_rel = 0, obs_rel = 0, n_grants = 0, n_acc = 0, acc_gap = 0, last_acc = 0;
  bit chk_rst = 1'b1, st_req = 1'b0, st_hold = 1'b0, st_clr = 1'b0;

  bit k_rstn = 1'b0, k_rdy = 1'b1, k_idr = 1'b1, k_flush = 1'b0, k_seq = 1'b1;
  logic [31:0] k_npc = '0;
  int k_dmin = 1, k_dmax = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
  endfunction

  function automatic bit mis(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
    if (mis(a)) return 32'h0;
`endif
    return mem_word(a);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check what the last edge produced, drive this cycle, predict the next edge.
  task automatic cycle();
    logic [31:0] npc;
    int   due;
    rsp_t r;
    @(negedge clk);
    cyc++;
    obs_rel = since_rel;
    if (chk_rst) begin
      check_eq("rst_if_valid", 32'(if_valid), 32'd0);
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_if_inst", if_inst, 32'd0);
      check_eq("rst_if_pc", if_pc, RESET_PC);
      chk_rst = 1'b0;
    end
    check_eq("imem_addr", imem_addr, exp_pc);
    check_eq("fetch_count", fetch_count, exp_cnt);
    if (if_valid) begin
      check_eq("if_pc", if_pc, exp_pc);
      check_eq("if_inst", if_inst, exp_inst(exp_pc));
      check_eq("no_req_in_hold", 32'(imem_req_valid), 32'd0);
    end
    if (st_req) begin
      check_eq("req_held", 32'(imem_req_valid), 32'd1);
      check_eq("req_addr_held", imem_addr, held_addr);
    end
    if (st_hold) check_eq("hold_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("misalign_flag", 32'(fetch_misalign), 32'(if_valid && mis(exp_pc)));
    if (mis(exp_pc)) check_eq("misalign_no_req", 32'(imem_req_valid), 32'd0);
`else
    if (st_clr) check_eq("clear_valid", 32'(if_valid), 32'd0);
`endif

    npc = k_seq ? ((exp_pc & ~32'h3) + 32'd4) : k_npc;
    rst_n = k_rstn; imem_req_ready = k_rdy; id_ready = k_idr; flush = k_flush; next_pc = npc;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].dat;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end

    st_req = 1'b0; st_hold = 1'b0; st_clr = 1'b0;
    if (!k_rstn) begin
      exp_pc = RESET_PC; exp_cnt = '0; chk_rst = 1'b1; since_rel = 0;
    end else begin
      since_rel++;
      if (imem_req_valid && k_rdy) begin
        due = cyc + $urandom_range(k_dmax, k_dmin);
        if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
        r.due = due; r.dat = mem_word(imem_addr);
        mq.push_back(r);
        n_grants++; last_grant_addr = imem_addr;
      end
      st_req = imem_req_valid && !k_rdy && !k_flush; held_addr = imem_addr;
      st_hold = if_valid && !k_idr && !k_flush;
      st_clr = k_flush || (if_valid && k_idr);
      if (k_flush) exp_pc = npc;
      else if (if_valid && k_idr) begin
        exp_cnt++; exp_pc = npc; n_acc++;
        acc_gap = cyc - last_acc; last_acc = cyc;
      end
    end
  endtask

  task automatic run_until_valid();
    for (int i = 0; i < 40; i++) begin cycle(); if (if_valid) break; end
    check_eq("wait_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic run_until_req();
    for (int i = 0; i < 40; i++) begin cycle(); if (imem_req_valid) break; end
    check_eq("wait_req", 32'(imem_req_valid), 32'd1);
  endtask

  task automatic run_until_grant();
    int g0;
    g0 = n_grants;
    for (int i = 0; i < 40; i++) begin cycle(); if (n_grants != g0) break; end
    check_eq("wait_grant", 32'(n_grants != g0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, pc0, inst0, c0;
    int g0;
    bit allow_rst;

    // Startup: first word visible four cycles after release, then one per three cycles.
    repeat (2) cycle();
    k_rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin cycle(); if (if_valid) break; end
    check_eq("first_valid_latency", 32'(obs_rel), 32'd3);
    check_eq("first_inst", if_inst, 32'h2008_0005);
    check_eq("first_pc", if_pc, 32'h0);
    cycle();
    check_eq("second_req_addr", last_grant_addr, 32'h4);
    check_eq("count_after_first", fetch_count, 32'd1);
    repeat (9) cycle();
    check_eq("throughput_gap", 32'(acc_gap), 32'd3);

    // Memory stalls the request for three cycles.
    k_rdy = 1'b0;
    run_until_req();
    a0 = imem_addr;
    repeat (2) begin
      cycle();
      check_eq("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("stall_addr", imem_addr, a0);
    end
    g0 = n_grants;
    k_rdy = 1'b1;
    run_until_valid();
    check_eq("stall_one_grant", 32'(n_grants - g0), 32'd1);

    // Decode stalls for five cycles in HOLD.
    k_idr = 1'b0;
    run_until_valid();
    pc0 = if_pc; inst0 = if_inst; c0 = fetch_count; g0 = n_grants;
    repeat (5) cycle();
    check_eq("hold_still_valid", 32'(if_valid), 32'd1);
    check_eq("hold_pc", if_pc, pc0);
    check_eq("hold_inst", if_inst, inst0);
    check_eq("hold_count", fetch_count, c0);
    check_eq("hold_no_req", 32'(n_grants - g0), 32'd0);
    k_idr = 1'b1;

    // Flush to the exception vector while a read is in flight; its reply lands two cycles later.
    k_dmin = 3; k_dmax = 3;
    run_until_grant();
    k_flush = 1'b1; k_seq = 1'b0; k_npc = 32'h0040_0004;
    cycle();
    k_flush = 1'b0; k_seq = 1'b1; k_dmin = 1; k_dmax = 1;
    run_until_grant();
    check_eq("flush_req_addr", last_grant_addr, 32'h0040_0004);
    run_until_valid();
    check_eq("flush_if_pc", if_pc, 32'h0040_0004);
    check_eq("flush_if_inst", if_inst, mem_word(32'h0040_0004));

    // Reset during WAIT; the reply arrives while the stage is rebooting.
    k_dmin = 2; k_dmax = 2;
    run_until_grant();
    k_rstn = 1'b0;
    cycle();
    k_rstn = 1'b1; k_dmin = 1; k_dmax = 1;
    cycle();
    check_eq("rst_count_zero", fetch_count, 32'd0);
    run_until_grant();
    check_eq("rst_restart_addr", last_grant_addr, RESET_PC);
    run_until_valid();
    check_eq("rst_first_inst", if_inst, 32'h2008_0005);

`ifdef FETCH_ALIGN_CHECK_EN
    run_until_valid();
    k_seq = 1'b0; k_npc = 32'h0000_0006;
    cycle();
    k_idr = 1'b0;
    cycle();
    check_eq("mis_if_valid", 32'(if_valid), 32'd1);
    check_eq("mis_flag", 32'(fetch_misalign), 32'd1);
    check_eq("mis_if_pc", if_pc, 32'h6);
    check_eq("mis_if_inst", if_inst, 32'h0);
    check_eq("mis_no_req", 32'(imem_req_valid), 32'd0);
    k_idr = 1'b1; k_seq = 1'b1;
    cycle();
`endif

    // Randomised traffic: stalls, flushes, variable memory latency, occasional reset.
    g0 = n_acc;
    k_seq = 1'b0; k_dmin = 1; k_dmax = 4;
    for (int i = 0; i < 3000; i++) begin
      allow_rst = (mq.size() == 0) || (mq.size() == 1 && mq[0].due <= cyc + 2);
      k_rstn  = !(allow_rst && $urandom_range(199, 0) == 0);
      k_rdy   = ($urandom_range(3, 0) != 0);
      k_idr   = ($urandom_range(2, 0) != 0);
      k_flush = ($urandom_range(15, 0) == 0);
      k_npc   = {20'h0, $urandom_range(1023, 0)[9:0], 2'b00};
      if ($urandom_range(7, 0) == 0) k_npc[1:0] = 2'($urandom_range(3, 0));
      cycle();
    end
    check_eq("random_progress", 32'(n_acc - g0 >= 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
